modn_updown_counter: RTL and testbench

//  Parametrised modulo-N up/down counter. Successor to the fixed mod-12 counter.

---
 rtl/modn_updown_counter.sv | 139 +++++++++++++
 tb/tb_modn_updown_counter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/modn_updown_counter.sv
// -----------------------------------------------------------------------------
// modn_updown_counter
//
// Parametrised modulo-N up/down counter used as a timebase / sequencer element.
// Counts over 0..MODULUS-1 in either direction, supports a range-checked
// synchronous load, registered one-cycle carry/borrow/load-error pulses, a
// combinational terminal-count flag and a one-shot mode that parks the counter
// in a HALT state at terminal count until the next valid load (or reset).
//
// Parameters
//   MODULUS  count range 0..MODULUS-1, legal 2..2**WIDTH
//   WIDTH    width of data_in / data_out
//
// Ports
//   clock     in   1      rising-edge clock
//   reset     in   1      asynchronous, active-high reset
//   enable    in   1      count enable
//   load      in   1      synchronous load request, wins over enable
//   mode      in   1      1 = count up, 0 = count down
//   one_shot  in   1      1 = halt at terminal count, 0 = wrap
//   data_in   in   WIDTH  load value
//   data_out  out  WIDTH  current count (registered)
//   tc        out  1      terminal count for the current direction
//   carry     out  1      one-cycle pulse after an up-wrap MODULUS-1 -> 0
//   borrow    out  1      one-cycle pulse after a down-wrap 0 -> MODULUS-1
//   load_err  out  1      one-cycle pulse after a rejected (out-of-range) load
//   done      out  1      high while halted in one-shot mode
// -----------------------------------------------------------------------------
module modn_updown_counter #(
    parameter int unsigned MODULUS = 12,
    parameter int unsigned WIDTH   = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic             mode,
    input  logic             one_shot,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             tc,
    output logic             carry,
    output logic             borrow,
    output logic             load_err,
    output logic             done
);

    // Reject illegal parameter combinations at elaboration time.
    if (WIDTH < 1 || WIDTH > 31 || MODULUS < 2 ||
        64'(MODULUS) > (64'(1) << WIDTH)) begin : g_param_check
        $error("modn_updown_counter: need 2 <= MODULUS <= 2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MaxCount = WIDTH'(MODULUS - 1);

    typedef enum logic [0:0] {
        StCount,
        StHalt
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] count_q;
    logic             carry_q;
    logic             borrow_q;
    logic             load_err_q;
    logic             done_q;

    logic at_max;
    logic at_zero;
    logic load_ok;

    always_comb begin
        at_max  = (count_q == MaxCount);
        at_zero = (count_q == '0);
        // When MODULUS == 2**WIDTH every data_in value is in range.
        load_ok = (data_in <= MaxCount);
    end

    // Single-process FSM: state, count and all flags are registered together so
    // the pulses line up with the data_out value that caused them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StCount;
            count_q    <= '0;
            carry_q    <= 1'b0;
            borrow_q   <= 1'b0;
            load_err_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // Pulses default low; re-asserted below only when re-caused.
            carry_q    <= 1'b0;
            borrow_q   <= 1'b0;
            load_err_q <= 1'b0;

            if (load) begin
                if (load_ok) begin
                    count_q <= data_in;
                    state_q <= StCount;
                    done_q  <= 1'b0;
                end else begin
                    load_err_q <= 1'b1;
                end
            end else if (enable && (state_q == StCount)) begin
                if (mode) begin
                    if (!at_max) begin
                        count_q <= count_q + WIDTH'(1);
                    end else if (!one_shot) begin
                        count_q <= '0;
                        carry_q <= 1'b1;
                    end else begin
                        state_q <= StHalt;
                        done_q  <= 1'b1;
                    end
                end else begin
                    if (!at_zero) begin
                        count_q <= count_q - WIDTH'(1);
                    end else if (!one_shot) begin
                        count_q  <= MaxCount;
                        borrow_q <= 1'b1;
                    end else begin
                        state_q <= StHalt;
                        done_q  <= 1'b1;
                    end
                end
            end
        end
    end

    assign data_out = count_q;
    assign carry    = carry_q;
    assign borrow   = borrow_q;
    assign load_err = load_err_q;
    assign done     = done_q;

    // Terminal count tracks mode combinationally so a direction change is seen
    // immediately, not one edge later.
    assign tc = mode ? at_max : at_zero;

endmodule

// File: tb/tb_modn_updown_counter.sv
module tb_modn_updown_counter;

    logic clock = 1'b0;
    logic reset = 1'b1;

    // MODULUS=12 instance signals
    logic       ld12 = 1'b0, en12 = 1'b0, md12 = 1'b1, os12 = 1'b0;
    logic [3:0] din12 = 4'd0;
    logic [3:0] do12;
    logic       tc12, c12, b12, e12, dn12;

    // MODULUS=16 instance signals
    logic       ld16 = 1'b0, en16 = 1'b0, md16 = 1'b1, os16 = 1'b0;
    logic [3:0] din16 = 4'd0;
    logic [3:0] do16;
    logic       tc16, c16, b16, e16, dn16;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      name;
        logic [8:0] exp;   // {data[3:0], tc, carry, borrow, load_err, done}
    } exp_t;

    exp_t q12[$];
    exp_t q16[$];

    always #5 clock = ~clock;

    modn_updown_counter #(.MODULUS(12), .WIDTH(4)) dut12 (
        .clock    (clock),
        .reset    (reset),
        .enable   (en12),
        .load     (ld12),
        .mode     (md12),
        .one_shot (os12),
        .data_in  (din12),
        .data_out (do12),
        .tc       (tc12),
        .carry    (c12),
        .borrow   (b12),
        .load_err (e12),
        .done     (dn12)
    );

    modn_updown_counter #(.MODULUS(16), .WIDTH(4)) dut16 (
        .clock    (clock),
        .reset    (reset),
        .enable   (en16),
        .load     (ld16),
        .mode     (md16),
        .one_shot (os16),
        .data_in  (din16),
        .data_out (do16),
        .tc       (tc16),
        .carry    (c16),
        .borrow   (b16),
        .load_err (e16),
        .done     (dn16)
    );

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got data=%0d flags(tc,c,b,e,d)=%b, expected data=%0d flags=%b",
                     name, act[8:5], act[4:0], exp[8:5], exp[4:0]);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge and queue the response
    // expected after the next rising edge.
    task automatic step(input int which, input string name,
                        input logic ld, input logic en, input logic md, input logic os,
                        input logic [3:0] din, input logic [3:0] ed, input logic [4:0] ef);
        exp_t e;
        @(negedge clock);
        e.name = name;
        e.exp  = {ed, ef};
        if (which == 0) begin
            ld12 = ld; en12 = en; md12 = md; os12 = os; din12 = din;
            q12.push_back(e);
        end else begin
            ld16 = ld; en16 = en; md16 = md; os16 = os; din16 = din;
            q16.push_back(e);
        end
    endtask

    task automatic idle12();
        ld12 = 1'b0; en12 = 1'b0;
    endtask

    // Monitor: compares the DUT outputs shortly after each rising edge.
    always begin : monitor
        exp_t e;
        @(posedge clock);
        #1;
        if (q12.size() > 0) begin
            e = q12.pop_front();
            check(e.name, {do12, tc12, c12, b12, e12, dn12}, e.exp);
        end
        if (q16.size() > 0) begin
            e = q16.pop_front();
            check(e.name, {do16, tc16, c16, b16, e16, dn16}, e.exp);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin : stimulus
        @(negedge clock);
        @(negedge clock);
        check("reset_state12", {do12, tc12, c12, b12, e12, dn12}, {4'd0, 5'b00000});
        check("reset_state16", {do16, tc16, c16, b16, e16, dn16}, {4'd0, 5'b00000});
        reset = 1'b0;

        // 1: up count through the wrap
        step(0, "t1_load9",  1, 0, 1, 0, 4'd9,  4'd9,  5'b00000);
        step(0, "t1_up10",   0, 1, 1, 0, 4'd0,  4'd10, 5'b00000);
        step(0, "t1_up11",   0, 1, 1, 0, 4'd0,  4'd11, 5'b10000);
        step(0, "t1_wrap0",  0, 1, 1, 0, 4'd0,  4'd0,  5'b01000);
        step(0, "t1_up1",    0, 1, 1, 0, 4'd0,  4'd1,  5'b00000);

        // 2: down count through the wrap
        step(0, "t2_load1",  1, 0, 0, 0, 4'd1,  4'd1,  5'b00000);
        step(0, "t2_dn0",    0, 1, 0, 0, 4'd0,  4'd0,  5'b10000);
        step(0, "t2_wrap11", 0, 1, 0, 0, 4'd0,  4'd11, 5'b00100);
        step(0, "t2_dn10",   0, 1, 0, 0, 4'd0,  4'd10, 5'b00000);

        // 3: out-of-range load rejected, in-range boundary accepted
        step(0, "t3_load5",  1, 0, 0, 0, 4'd5,  4'd5,  5'b00000);
        step(0, "t3_load13", 1, 0, 0, 0, 4'd13, 4'd5,  5'b00010);
        step(0, "t3_load11", 1, 0, 1, 0, 4'd11, 4'd11, 5'b10000);

        // 4: one-shot up, halt, rejected load keeps halt, valid load resumes
        step(0, "t4_load9",  1, 0, 1, 1, 4'd9,  4'd9,  5'b00000);
        step(0, "t4_up10",   0, 1, 1, 1, 4'd0,  4'd10, 5'b00000);
        step(0, "t4_up11",   0, 1, 1, 1, 4'd0,  4'd11, 5'b10000);
        step(0, "t4_halt_a", 0, 1, 1, 1, 4'd0,  4'd11, 5'b10001);
        step(0, "t4_halt_b", 0, 1, 1, 1, 4'd0,  4'd11, 5'b10001);
        step(0, "t4_badld",  1, 1, 1, 1, 4'd14, 4'd11, 5'b10011);
        step(0, "t4_load3",  1, 1, 1, 1, 4'd3,  4'd3,  5'b00000);
        step(0, "t4_up4",    0, 1, 1, 1, 4'd0,  4'd4,  5'b00000);
        step(0, "t4_up5",    0, 1, 1, 1, 4'd0,  4'd5,  5'b00000);

        // one-shot down to zero
        step(0, "t4d_load1", 1, 0, 0, 1, 4'd1,  4'd1,  5'b00000);
        step(0, "t4d_dn0",   0, 1, 0, 1, 4'd0,  4'd0,  5'b10000);
        step(0, "t4d_halt",  0, 1, 0, 1, 4'd0,  4'd0,  5'b10001);
        step(0, "t4d_load2", 1, 0, 0, 1, 4'd2,  4'd2,  5'b00000);

        // 5: load beats enable, then hold
        step(0, "t5_load7",  1, 1, 1, 0, 4'd7,  4'd7,  5'b00000);
        for (int i = 0; i < 5; i++) begin
            step(0, $sformatf("t5_hold%0d", i), 0, 0, 1, 0, 4'd0, 4'd7, 5'b00000);
        end
        // direction change takes effect on the same edge
        step(0, "t5_dn6",    0, 1, 0, 0, 4'd0,  4'd6,  5'b00000);
        step(0, "t5_up7",    0, 1, 1, 0, 4'd0,  4'd7,  5'b00000);

        // 6: async reset between edges while carry is high
        step(0, "t6_load11", 1, 0, 1, 0, 4'd11, 4'd11, 5'b10000);
        step(0, "t6_carry",  0, 1, 1, 0, 4'd0,  4'd0,  5'b01000);
        @(posedge clock);
        #2 reset = 1'b1;
        #1 check("t6_async_rst", {do12, tc12, c12, b12, e12, dn12}, {4'd0, 5'b00000});
        @(negedge clock);
        check("t6_rst_hold", {do12, tc12, c12, b12, e12, dn12}, {4'd0, 5'b00000});
        idle12();
        reset = 1'b0;
        step(0, "t6_resume1", 0, 1, 1, 0, 4'd0, 4'd1, 5'b00000);

        // async reset clears done and leaves HALT
        step(0, "t6h_load11", 1, 0, 1, 1, 4'd11, 4'd11, 5'b10000);
        step(0, "t6h_halt",   0, 1, 1, 1, 4'd0,  4'd11, 5'b10001);
        @(posedge clock);
        #2 reset = 1'b1;
        #1 check("t6h_async_rst", {do12, tc12, c12, b12, e12, dn12}, {4'd0, 5'b00000});
        @(negedge clock);
        idle12();
        reset = 1'b0;
        step(0, "t6h_resume1", 0, 1, 1, 1, 4'd0, 4'd1, 5'b00000);
        @(negedge clock);
        idle12();

        // MODULUS=16: natural wrap both ways, full-range load accepted
        step(1, "m16_load14", 1, 0, 1, 0, 4'd14, 4'd14, 5'b00000);
        step(1, "m16_up15",   0, 1, 1, 0, 4'd0,  4'd15, 5'b10000);
        step(1, "m16_wrap0",  0, 1, 1, 0, 4'd0,  4'd0,  5'b01000);
        step(1, "m16_up1",    0, 1, 1, 0, 4'd0,  4'd1,  5'b00000);
        step(1, "m16_load0",  1, 0, 0, 0, 4'd0,  4'd0,  5'b10000);
        step(1, "m16_wrap15", 0, 1, 0, 0, 4'd0,  4'd15, 5'b00100);
        step(1, "m16_load15", 1, 0, 1, 0, 4'd15, 4'd15, 5'b10000);
        @(negedge clock);
        ld16 = 1'b0; en16 = 1'b0;

        repeat (3) @(negedge clock);
        check("drain12", 9'(q12.size()), 9'd0);
        check("drain16", 9'(q16.size()), 9'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
